// File: rtl/hc_reduce.sv
// Row-wise FP16 reduction of the hC tensor over the state axis, using PAR
// pipelined FP16 adder lanes driven by a multi-pass issue/drain FSM.

module fp16_add_wrapper #(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result
);

  logic [LAT-1:0] vld_p;
  logic [15:0]    res_p [LAT];

  // IEEE-754 binary16 addition, round-to-nearest-even, with subnormals.
  function automatic logic [15:0] fp16_add(input logic [15:0] a_in, input logic [15:0] b_in);
    logic        swap, sx, sy, sticky, up;
    logic [15:0] x, y;
    logic [5:0]  ex, ey, e;
    logic [4:0]  d;
    logic [10:0] mx, my, m;
    logic [13:0] ax, ay, wide, norm;
    logic [14:0] sum;
    logic [11:0] mr;
    int          msb, sh;
    if ((a_in[14:10] == 5'h1F && a_in[9:0] != 10'd0) ||
        (b_in[14:10] == 5'h1F && b_in[9:0] != 10'd0))
      return 16'h7E00;
    if (a_in[14:10] == 5'h1F && b_in[14:10] == 5'h1F)
      return (a_in[15] != b_in[15]) ? 16'h7E00 : a_in;
    if (a_in[14:10] == 5'h1F) return a_in;
    if (b_in[14:10] == 5'h1F) return b_in;
    swap = b_in[14:0] > a_in[14:0];
    x    = swap ? b_in : a_in;
    y    = swap ? a_in : b_in;
    sx   = x[15];
    sy   = y[15];
    ex   = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
    ey   = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
    mx   = {x[14:10] != 5'd0, x[9:0]};
    my   = {y[14:10] != 5'd0, y[9:0]};
    d    = 5'(ex - ey);
    ax   = {mx, 3'b000};
    wide = {my, 3'b000};
    if (d >= 5'd14) begin
      ay     = '0;
      sticky = |my;
    end else begin
      ay     = wide >> d;
      sticky = |(wide & ((14'd1 << d) - 14'd1));
    end
    ay[0] = ay[0] | sticky;
    e     = ex;
    if (sx == sy) begin
      sum = {1'b0, ax} + {1'b0, ay};
      if (sum[14]) begin
        norm    = sum[14:1];
        norm[0] = norm[0] | sum[0];
        e       = ex + 6'd1;
      end else begin
        norm = sum[13:0];
      end
    end else begin
      sum = {1'b0, ax} - {1'b0, ay};
      if (sum == 15'd0) return 16'h0000;
      msb = 0;
      for (int k = 0; k < 14; k++)
        if (sum[k]) msb = k;
      sh = 13 - msb;
      // Left-normalise only down to the subnormal exponent.
      if (sh > int'(ex) - 1) sh = int'(ex) - 1;
      norm = sum[13:0] << sh;
      e    = ex - 6'(sh);
    end
    m  = norm[13:3];
    up = norm[2] & ((|norm[1:0]) | norm[3]);
    mr = {1'b0, m} + {11'd0, up};
    if (mr[11]) begin
      m = mr[11:1];
      e = e + 6'd1;
    end else begin
      m = mr[10:0];
    end
    if (e >= 6'd31) return {sx, 5'h1F, 10'h000};
    return {sx, m[10] ? e[4:0] : 5'd0, m[9:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= (vld_p << 1) | LAT'(valid_in);
  end

  // Stage p0 computes the sum; later stages only delay it.
  always_ff @(posedge clk) begin
    res_p[0] <= fp16_add(a, b);
    for (int k = 1; k < LAT; k++) res_p[k] <= res_p[k-1];
  end

  assign valid_out = vld_p[LAT-1];
  assign result    = res_p[LAT-1];

endmodule

module hc_reduce #(
  parameter int B     = 1,
  parameter int H     = 4,
  parameter int P     = 4,
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int A_LAT = 8,
  parameter int PAR   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [B*H*P*N*DW-1:0]   hC_flat,
  output logic [B*H*P*DW-1:0]     y_flat,
  output logic                    done
);

  localparam int R  = B * H * P;
  localparam int G  = (R + PAR - 1) / PAR;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(A_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grp;
  logic [NW-1:0]   n_idx;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   acc [R];

  logic [PAR-1:0]  lane_ok, vld_issue, vld_p0, add_vld, wb;
  logic [RW-1:0]   lane_idx  [PAR];
  logic [DW-1:0]   lane_a    [PAR];
  logic [DW-1:0]   lane_b    [PAR];
  logic [DW-1:0]   lane_a_p0 [PAR];
  logic [DW-1:0]   lane_b_p0 [PAR];
  logic [DW-1:0]   add_res   [PAR];
  logic [RW-1:0]   tag_p     [PAR][A_LAT+1];
  logic [A_LAT:0]  tag_vld   [PAR];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (N == 1) ? S_DONE : S_ISSUE;
      S_ISSUE: if (grp == GW'(G - 1)) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == CW'(A_LAT))
                 state_nxt = (n_idx == NW'(N - 1)) ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grp   <= '0;
      n_idx <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);
      case (state)
        S_LOAD: begin
          n_idx <= NW'(1);
          grp   <= '0;
        end
        S_ISSUE: begin
          cnt <= '0;
          grp <= (grp == GW'(G - 1)) ? '0 : grp + GW'(1);
        end
        S_DRAIN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(A_LAT) && n_idx != NW'(N - 1)) n_idx <= n_idx + NW'(1);
        end
        default: ;
      endcase
    end
  end

  // Lane i of group grp handles row grp*PAR+i; rows past R stay idle.
  always_comb begin
    for (int i = 0; i < PAR; i++) begin
      lane_ok[i]  = 1'b0;
      lane_idx[i] = '0;
      lane_a[i]   = '0;
      lane_b[i]   = '0;
      if (int'(grp) * PAR + i < R) begin
        lane_ok[i]  = 1'b1;
        lane_idx[i] = RW'(int'(grp) * PAR + i);
        lane_a[i]   = acc[lane_idx[i]];
        lane_b[i]   = hC_flat[(int'(lane_idx[i]) * N + int'(n_idx)) * DW +: DW];
      end
    end
    vld_issue = (state == S_ISSUE) ? lane_ok : '0;
  end

  // Stage p0: registered adder operands, valid and row tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
      for (int i = 0; i < PAR; i++) tag_vld[i] <= '0;
    end else begin
      vld_p0 <= vld_issue;
      for (int i = 0; i < PAR; i++) tag_vld[i] <= {tag_vld[i][A_LAT-1:0], vld_issue[i]};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PAR; i++) begin
      lane_a_p0[i] <= lane_a[i];
      lane_b_p0[i] <= lane_b[i];
      tag_p[i][0]  <= lane_idx[i];
      for (int k = 1; k <= A_LAT; k++) tag_p[i][k] <= tag_p[i][k-1];
    end
  end

  for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
    fp16_add_wrapper #(.LAT(A_LAT)) u_add (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (vld_p0[gi]),
      .a         (lane_a_p0[gi]),
      .b         (lane_b_p0[gi]),
      .valid_out (add_vld[gi]),
      .result    (add_res[gi])
    );
    assign wb[gi] = add_vld[gi] & tag_vld[gi][A_LAT];
  end

  // Stage A_LAT: write-back, row chosen by the tag that travelled with the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < R; r++) acc[r] <= '0;
    end else begin
      if (state == S_LOAD)
        for (int r = 0; r < R; r++) acc[r] <= hC_flat[r * N * DW +: DW];
      for (int i = 0; i < PAR; i++)
        if (wb[i]) acc[tag_p[i][A_LAT]] <= add_res[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_flat <= '0;
    end else if (state == S_DONE) begin
      for (int r = 0; r < R; r++) y_flat[r * DW +: DW] <= acc[r];
    end
  end

endmodule
